// File: rtl/posit_decode_pipe.sv
// Two-stage, multi-lane posit decoder with valid/ready handshake.
// Stage 1 finds sign, magnitude and regime run; stage 2 extracts k, exponent and mantissa.
module posit_decode_pipe #(
  parameter int N     = 16,
  parameter int ES    = 2,
  parameter int LANES = 2,
  parameter int RS    = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*N-1:0]      in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_sign,
  output logic [LANES*(RS+3)-1:0] out_k,
  output logic [LANES*ES-1:0]     out_exp,
  output logic [LANES*N-1:0]      out_mant,
  output logic [LANES-1:0]        out_zero,
  output logic [LANES-1:0]        out_nar
);

  localparam int KW = RS + 3;
  localparam int RW = N - 1;
  localparam logic [N-1:0]  NAR_WORD = {1'b1, {(N-1){1'b0}}};
  localparam logic [RS:0]   SH_ONE   = (RS+1)'(1);

  logic s1_valid;
  logic s2_adv;
  logic in_fire;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign in_fire  = in_valid && in_ready;

  // Stage 1 combinational decode: sign, |rem|, regime bit and run length
  logic [LANES-1:0]    d1_sign, d1_r0, d1_zero, d1_nar;
  logic [LANES*RW-1:0] d1_rem;
  logic [LANES*RS-1:0] d1_m;

  always_comb begin : s1_decode
    logic [N-1:0]  w;
    logic [RW-1:0] r;
    logic [RS-1:0] run;
    logic          done;
    d1_sign = '0;
    d1_r0   = '0;
    d1_zero = '0;
    d1_nar  = '0;
    d1_rem  = '0;
    d1_m    = '0;
    w       = '0;
    r       = '0;
    run     = '0;
    done    = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w    = in_data[l*N +: N];
      r    = w[N-1] ? (~w[N-2:0] + RW'(1)) : w[N-2:0];
      run  = '0;
      done = 1'b0;
      for (int unsigned j = 0; j < RW; j++) begin
        if (!done) begin
          if (r[RW-1-j] == r[RW-1]) run = run + RS'(1);
          else                      done = 1'b1;
        end
      end
      d1_sign[l]            = w[N-1];
      d1_rem[l*RW +: RW]    = r;
      d1_r0[l]              = r[RW-1];
      d1_m[l*RS +: RS]      = run;
      d1_zero[l]            = (w == '0);
      d1_nar[l]             = (w == NAR_WORD);
    end
  end

  logic [LANES-1:0]    s1_sign, s1_r0, s1_zero, s1_nar;
  logic [LANES*RW-1:0] s1_rem;
  logic [LANES*RS-1:0] s1_m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= '0;
      s1_r0    <= '0;
      s1_zero  <= '0;
      s1_nar   <= '0;
      s1_rem   <= '0;
      s1_m     <= '0;
    end else begin
      if (flush)        s1_valid <= 1'b0;
      else if (in_fire) s1_valid <= 1'b1;
      else if (s2_adv)  s1_valid <= 1'b0;
      if (in_fire) begin
        s1_sign <= d1_sign;
        s1_r0   <= d1_r0;
        s1_zero <= d1_zero;
        s1_nar  <= d1_nar;
        s1_rem  <= d1_rem;
        s1_m    <= d1_m;
      end
    end
  end

  // Stage 2: shifting past regime and terminator leaves exponent then fraction at the MSB;
  // a shift of N (no terminator) empties the body, giving exp=0 and a bare hidden bit.
  logic [LANES*KW-1:0] d2_k;
  logic [LANES*ES-1:0] d2_exp;
  logic [LANES*N-1:0]  d2_mant;

  always_comb begin : s2_fields
    logic [RW-1:0] body;
    logic [RS:0]   sh;
    logic [KW-1:0] mk;
    d2_k    = '0;
    d2_exp  = '0;
    d2_mant = '0;
    body    = '0;
    sh      = '0;
    mk      = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      sh   = {1'b0, s1_m[l*RS +: RS]} + SH_ONE;
      body = s1_rem[l*RW +: RW] << sh;
      mk   = {3'b000, s1_m[l*RS +: RS]};
      if (s1_zero[l] || s1_nar[l]) begin
        d2_k[l*KW +: KW]   = '0;
        d2_exp[l*ES +: ES] = '0;
        d2_mant[l*N +: N]  = '0;
      end else begin
        d2_k[l*KW +: KW]   = s1_r0[l] ? (mk - KW'(1)) : ('0 - mk);
        d2_exp[l*ES +: ES] = body[RW-1 -: ES];
        d2_mant[l*N +: N]  = {1'b1, body[RW-1-ES:0], {ES{1'b0}}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sign  <= '0;
      out_k     <= '0;
      out_exp   <= '0;
      out_mant  <= '0;
      out_zero  <= '0;
      out_nar   <= '0;
    end else begin
      if (flush)       out_valid <= 1'b0;
      else if (s2_adv) out_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        out_sign <= s1_sign;
        out_k    <= d2_k;
        out_exp  <= d2_exp;
        out_mant <= d2_mant;
        out_zero <= s1_zero;
        out_nar  <= s1_nar;
      end
    end
  end

endmodule

// File: doc/posit_decode_pipe.md
POSIT_DECODE_PIPE -- requirements
Module: posit_decode_pipe

Parameters
REQ-001 SHALL have parameter N, default 16, meaning posit word width in bits (N >= 4).
REQ-002 SHALL have parameter ES, default 2, meaning exponent field width (1 <= ES <= N-3).
REQ-003 SHALL have parameter LANES, default 2, meaning independent posit words decoded per transfer.
REQ-004 SHALL have parameter RS, default $clog2(N), meaning regime-count width; k is RS+3 bits signed.

Interface
REQ-005 clk  input  1  rising-edge clock; single clock domain.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 flush  input  1  synchronous; drops all in-flight words.
REQ-008 in_valid  input  1  in_data holds LANES words.
REQ-009 in_ready  output  1  pipeline accepts in_data this cycle.
REQ-010 in_data  input  LANES*N  lane i occupies bits [i*N +: N].
REQ-011 out_valid  output  1  decoded fields are valid.
REQ-012 out_ready  input  1  consumer accepts outputs this cycle.
REQ-013 out_sign  output  LANES  per-lane sign bit.
REQ-014 out_k  output  LANES*(RS+3)  per-lane signed regime value k.
REQ-015 out_exp  output  LANES*ES  per-lane exponent field.
REQ-016 out_mant  output  LANES*N  per-lane mantissa, hidden 1 at MSB, fraction left-aligned.
REQ-017 out_zero, out_nar  output  LANES each  per-lane zero / NaR flags.

Function
REQ-018 Decode per lane: sign = bit N-1; rem = bits N-2..0, two's-complemented in N-1 bits when sign=1.
REQ-019 Regime: r0 = rem[N-2]; m = run length of bits equal to r0 from N-2 downward (1..N-1); k = m-1 if r0=1, else -m.
REQ-020 Exponent: the ES bits after the terminating bit (bit N-2-m), MSB first; bits beyond bit 0 SHALL read as 0.
REQ-021 Mantissa: {1, remaining bits after exponent, zero-filled to N bits}.
REQ-022 All-equal rem (no terminator): k per REQ-019 with m=N-1, exp=0, mant = 1 followed by zeros.
REQ-023 Word 0: out_zero=1; NaR (1 then N-1 zeros): out_nar=1; both cases force k, exp, mant to 0 and sign as input.
REQ-024 Pipeline: 2 stages; stage 1 registers sign, rem, r0, m, zero/nar; stage 2 registers shifted fields.
REQ-025 Latency: an accepted word appears on outputs exactly 2 cycles after acceptance when out_ready stays 1.
REQ-026 Throughput: one transfer per cycle sustained when out_ready=1.
REQ-027 Transfer on a port occurs when valid and ready are both 1 at a rising edge.
REQ-028 in_ready = !stage1_valid || stage2 advances this cycle; stage2 advances when !out_valid || out_ready.
REQ-029 While out_valid=1 and out_ready=0, all out_* SHALL hold stable, and no word is dropped or duplicated.
REQ-030 in_valid may drop without a transfer; in_data is sampled only on a transfer.
REQ-031 Lanes are fully independent; mixed zero/NaR/normal lanes in one transfer decode correctly.
REQ-032 flush=1 clears both stage valids at the next edge; an in_valid transfer in the flush cycle is discarded.
REQ-033 flush and stall together: flush wins; out_valid=0 next cycle.

Reset
REQ-034 rst_n=0 SHALL immediately clear both stage valids; out_valid=0 and all out_* data = 0 while in reset.
REQ-035 in_ready SHALL be 1 from the first edge after reset release.
REQ-036 Reset asserted mid-stream discards all in-flight words; no output transfer follows release until new input.

Verification
REQ-037 N=16, ES=2, lane0=0x4000, lane1=0x5000 -> 2 cycles later: k=0/0, exp=0/2, mant=0x8000/0x8000, sign=0/0.
REQ-038 lane0=0x4A00, lane1=0xC000 -> k=0/0, exp=1/0, mant=0xA000/0x8000, sign=0/1.
REQ-039 lane0=0x7FFF, lane1=0x0001 -> k=14/-14, exp=0/0, mant=0x8000/0x8000.
REQ-040 lane0=0x0000, lane1=0x8000 -> zero=1/0, nar=0/1, k, exp, mant all 0.
REQ-041 Stream 8 transfers with out_ready toggled randomly -> outputs in order, none lost, held stable during stall.
REQ-042 flush with both stages full, then rst_n pulse mid-stream -> out_valid=0 next cycle, in_ready=1, no stale outputs.
